// File: rtl/ucode_seq.sv
// ucode_seq: two-step microcode sequencer producing per-step control strobes.
// Optional: define UCODE_SEQ_ILLEGAL_TRAP_EN for a sticky illegal-opcode flag.
module ucode_seq #(
  parameter int DW   = 8,
  parameter int IDXW = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [7:0]      opcode,
  input  logic [DW-1:0]   w,
  input  logic            carry,
  input  logic            zero,
  output logic            ctrl_valid,
  output logic            step,
  output logic            alu_op,
  output logic            alu_mb,
  output logic            jmp_op,
  output logic            jmp_cond,
  output logic            mov_op,
  output logic            dst_w,
  output logic            dst_f,
  output logic            dst_mem,
  output logic            dst_reg,
  output logic            dst_port,
  output logic            ram_op,
  output logic            dup_w,
  output logic            stack_push,
  output logic [IDXW-1:0] dst_index,
  output logic            illegal
);

  localparam int BW = $clog2(DW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S0   = 2'd1,
    S1   = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [7:0]    op_q;
  logic [DW-1:0] w_q;
  logic          c_q;
  logic          z_q;
  logic          accept;

  function automatic logic in_rng(
    input logic [7:0] v,
    input logic [7:0] lo,
    input logic [7:0] hi
  );
    return (v >= lo) && (v <= hi);
  endfunction

  // Opcode groups of the captured instruction
  logic g_alu_w, g_alu_f, g_alu_grp, g_alu_mw;
  logic g_mov_p, g_mov_pw, g_mov_r, g_mov_rw;
  logic g_mov_mw, g_mov_wm, g_mov_lw;
  logic g_mul, g_xch, g_call, g_jmp, two_step;
  logic [BW-1:0] bit_sel;
  logic jc_val;

  // ALU LW/MW pairs share 0x88-0x8F and 0x94-0x9F; opcode bit 1 picks memory
  assign g_alu_grp = in_rng(op_q, 8'h88, 8'h8F)
                   | in_rng(op_q, 8'h94, 8'h9F);
  assign g_alu_mw  = g_alu_grp & op_q[1];
  assign g_alu_w   = in_rng(op_q, 8'h01, 8'h03)
                   | in_rng(op_q, 8'h06, 8'h0A)
                   | in_rng(op_q, 8'h60, 8'h6F)
                   | (g_alu_grp & ~op_q[1]);
  assign g_alu_f   = in_rng(op_q, 8'h04, 8'h05);
  assign g_mov_p   = in_rng(op_q, 8'h40, 8'h41);
  assign g_mov_pw  = in_rng(op_q, 8'h48, 8'h49);
  assign g_mov_r   = in_rng(op_q, 8'h50, 8'h57);
  assign g_mov_rw  = in_rng(op_q, 8'h58, 8'h5F);
  assign g_mov_mw  = in_rng(op_q, 8'h80, 8'h81);
  assign g_mov_wm  = in_rng(op_q, 8'h82, 8'h83)
                   | in_rng(op_q, 8'h86, 8'h87);
  assign g_mov_lw  = in_rng(op_q, 8'h84, 8'h85);
  assign g_mul     = in_rng(op_q, 8'h90, 8'h93);
  assign g_xch     = in_rng(op_q, 8'hA0, 8'hA1);
  assign g_call    = in_rng(op_q, 8'hA8, 8'hA9);
  assign g_jmp     = in_rng(op_q, 8'hA2, 8'hA7)
                   | in_rng(op_q, 8'hE0, 8'hFF);
  assign two_step  = g_mul | g_xch | g_call;

  // Bit test only reaches w[7:0]; the index never exceeds 7
  assign bit_sel = BW'(op_q[3:1]);

  always_comb begin
    jc_val = 1'b0;
    unique case (1'b1)
      in_rng(op_q, 8'hA2, 8'hA3): jc_val = 1'b1;
      in_rng(op_q, 8'hA4, 8'hA5): jc_val = c_q;
      in_rng(op_q, 8'hA6, 8'hA7): jc_val = z_q;
      in_rng(op_q, 8'hE0, 8'hEF): jc_val = ~w_q[bit_sel];
      in_rng(op_q, 8'hF0, 8'hFF): jc_val = w_q[bit_sel];
      default:                    jc_val = 1'b0;
    endcase
  end

  always_comb begin
    op_ready = 1'b1;
    if (state == S0)
      op_ready = ~two_step;
  end

  assign accept = op_valid & op_ready;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = S0;
      S0: begin
        if (two_step)    state_nx = S1;
        else if (accept) state_nx = S0;
        else             state_nx = IDLE;
      end
      S1: state_nx = accept ? S0 : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_q  <= 8'h00;
      w_q   <= '0;
      c_q   <= 1'b0;
      z_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_q <= opcode;
        w_q  <= w;
        c_q  <= carry;
        z_q  <= zero;
      end
    end
  end

  always_comb begin
    ctrl_valid = 1'b0;
    step       = 1'b0;
    alu_op     = 1'b0;
    alu_mb     = 1'b0;
    jmp_op     = 1'b0;
    jmp_cond   = 1'b0;
    mov_op     = 1'b0;
    dst_w      = 1'b0;
    dst_f      = 1'b0;
    dst_mem    = 1'b0;
    dst_reg    = 1'b0;
    dst_port   = 1'b0;
    ram_op     = 1'b0;
    dup_w      = 1'b0;
    stack_push = 1'b0;
    dst_index  = '0;
    if (state == S0) begin
      ctrl_valid = 1'b1;
      unique case (1'b1)
        g_alu_w: begin
          alu_op = 1'b1;
          dst_w  = 1'b1;
        end
        g_alu_mw: begin
          alu_op = 1'b1;
          dst_w  = 1'b1;
          ram_op = 1'b1;
        end
        g_alu_f: begin
          alu_op = 1'b1;
          dst_f  = 1'b1;
        end
        g_mov_p: begin
          mov_op    = 1'b1;
          dst_port  = 1'b1;
          dst_index = IDXW'(op_q[2:0]);
        end
        g_mov_r: begin
          mov_op    = 1'b1;
          dst_reg   = 1'b1;
          dst_index = IDXW'(op_q[2:0]);
        end
        g_mov_pw, g_mov_rw: begin
          mov_op    = 1'b1;
          dst_w     = 1'b1;
          dst_index = IDXW'(op_q[2:0]);
        end
        g_mov_mw: begin
          mov_op = 1'b1;
          dst_w  = 1'b1;
          ram_op = 1'b1;
        end
        g_mov_wm: begin
          mov_op  = 1'b1;
          dst_mem = 1'b1;
        end
        g_mov_lw: begin
          mov_op = 1'b1;
          dst_w  = 1'b1;
        end
        g_mul: begin
          alu_op = 1'b1;
          alu_mb = 1'b1;
          dst_w  = 1'b1;
          ram_op = op_q[1];
        end
        g_xch: begin
          mov_op = 1'b1;
          dup_w  = 1'b1;
        end
        g_call: stack_push = 1'b1;
        g_jmp: begin
          jmp_op   = 1'b1;
          jmp_cond = jc_val;
        end
        default: ;
      endcase
    end else if (state == S1) begin
      ctrl_valid = 1'b1;
      step       = 1'b1;
      unique case (1'b1)
        g_mul: begin
          alu_op  = 1'b1;
          alu_mb  = 1'b1;
          dst_mem = 1'b1;
          ram_op  = op_q[1];
        end
        g_xch: begin
          mov_op  = 1'b1;
          dst_w   = 1'b1;
          dst_mem = 1'b1;
        end
        g_call: begin
          jmp_op   = 1'b1;
          jmp_cond = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef UCODE_SEQ_ILLEGAL_TRAP_EN
  logic ill_op;
  logic ill_q;

  assign ill_op = in_rng(opcode, 8'h0B, 8'h3F)
                | in_rng(opcode, 8'h42, 8'h47)
                | in_rng(opcode, 8'h4A, 8'h4F)
                | in_rng(opcode, 8'h70, 8'h7F)
                | in_rng(opcode, 8'hAA, 8'hDF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ill_q <= 1'b0;
    else if (accept && ill_op)
      ill_q <= 1'b1;
  end

  assign illegal = ill_q;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_ucode_seq.sv
// tb_ucode_seq: directed-vector bench for ucode_seq.
// Outputs packed into one signature word and compared with hand values.
module tb_ucode_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       op_valid;
  logic       op_ready;
  logic [7:0] opcode;
  logic [7:0] w;
  logic       carry, zero;
  logic       ctrl_valid, step, alu_op, alu_mb, jmp_op, jmp_cond;
  logic       mov_op, dst_w, dst_f, dst_mem, dst_reg, dst_port;
  logic       ram_op, dup_w, stack_push, illegal;
  logic [2:0] dst_index;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ucode_seq #(.DW(8), .IDXW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_ready(op_ready),
    .opcode(opcode), .w(w), .carry(carry), .zero(zero),
    .ctrl_valid(ctrl_valid), .step(step),
    .alu_op(alu_op), .alu_mb(alu_mb),
    .jmp_op(jmp_op), .jmp_cond(jmp_cond),
    .mov_op(mov_op), .dst_w(dst_w), .dst_f(dst_f),
    .dst_mem(dst_mem), .dst_reg(dst_reg), .dst_port(dst_port),
    .ram_op(ram_op), .dup_w(dup_w), .stack_push(stack_push),
    .dst_index(dst_index), .illegal(illegal)
  );

  localparam logic [19:0] PUSH = 20'h1 << 0;
  localparam logic [19:0] DUP  = 20'h1 << 1;
  localparam logic [19:0] RAM  = 20'h1 << 2;
  localparam logic [19:0] DPRT = 20'h1 << 3;
  localparam logic [19:0] DREG = 20'h1 << 4;
  localparam logic [19:0] DMEM = 20'h1 << 5;
  localparam logic [19:0] DF   = 20'h1 << 6;
  localparam logic [19:0] DW_  = 20'h1 << 7;
  localparam logic [19:0] MOV  = 20'h1 << 8;
  localparam logic [19:0] JC   = 20'h1 << 9;
  localparam logic [19:0] JMP  = 20'h1 << 10;
  localparam logic [19:0] MB   = 20'h1 << 11;
  localparam logic [19:0] ALU  = 20'h1 << 12;
  localparam logic [19:0] STP  = 20'h1 << 13;
  localparam logic [19:0] CV   = 20'h1 << 14;
  localparam logic [19:0] RDY  = 20'h1 << 18;
  localparam logic [19:0] ILL  = 20'h1 << 19;
`ifdef UCODE_SEQ_ILLEGAL_TRAP_EN
  localparam logic [19:0] ILX  = ILL;
`else
  localparam logic [19:0] ILX  = 20'h0;
`endif

  logic [19:0] sig;
  assign sig = {illegal, op_ready, dst_index, ctrl_valid, step,
                alu_op, alu_mb, jmp_op, jmp_cond, mov_op, dst_w,
                dst_f, dst_mem, dst_reg, dst_port, ram_op, dup_w,
                stack_push};

  function automatic logic [19:0] idx(input int i);
    return 20'(i) << 15;
  endfunction

  task automatic check(input string tag,
                       input logic [19:0] got,
                       input logic [19:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %05h expected %05h", tag, got, exp);
    end
  endtask

  // Offer an opcode and return at the negedge after the accepting edge
  task automatic issue(input logic [7:0] op, input logic [7:0] wv,
                       input logic c, input logic z);
    op_valid = 1'b1;
    opcode   = op;
    w        = wv;
    carry    = c;
    zero     = z;
    @(negedge clk);
  endtask

  task automatic idle_cyc();
    op_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; op_valid = 1'b0; opcode = 8'h00;
    w = 8'h00; carry = 1'b0; zero = 1'b0;
    repeat (2) @(negedge clk);
    check("reset", sig, RDY);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle", sig, RDY);

    issue(8'h53, 8'h00, 0, 0);
    op_valid = 1'b0;
    check("mov_r53", sig, CV | MOV | DREG | idx(3) | RDY);
    @(negedge clk);
    check("idle53", sig, RDY);

    issue(8'h90, 8'h00, 0, 0);
    opcode = 8'h02;
    check("mul_s0", sig, CV | ALU | MB | DW_);
    @(negedge clk);
    check("mul_s1", sig, CV | STP | ALU | MB | DMEM | RDY);
    @(negedge clk);
    op_valid = 1'b0;
    check("after_mul", sig, CV | ALU | DW_ | RDY);
    idle_cyc();

    issue(8'hF6, 8'h08, 0, 0);
    op_valid = 1'b0; w = 8'h00; #1;
    check("jbs_set", sig, CV | JMP | JC | RDY);
    idle_cyc();
    issue(8'hE6, 8'h08, 0, 0);
    op_valid = 1'b0; w = 8'hFF; #1;
    check("jbc_set", sig, CV | JMP | RDY);
    idle_cyc();

    issue(8'hA4, 8'h00, 1, 0);
    op_valid = 1'b0; carry = 1'b0; #1;
    check("jc", sig, CV | JMP | JC | RDY);
    issue(8'hA6, 8'h00, 1, 0);
    op_valid = 1'b0; zero = 1'b1; #1;
    check("jz", sig, CV | JMP | RDY);
    issue(8'hA2, 8'h00, 0, 0);
    op_valid = 1'b0;
    check("jmp", sig, CV | JMP | JC | RDY);

    issue(8'h01, 8'h00, 0, 0);
    opcode = 8'h5A;
    check("alu01", sig, CV | ALU | DW_ | RDY);
    @(negedge clk);
    op_valid = 1'b0;
    check("mov_rw5a", sig, CV | MOV | DW_ | idx(2) | RDY);
    issue(8'h04, 8'h00, 0, 0);
    op_valid = 1'b0;
    check("alu_f", sig, CV | ALU | DF | RDY);
    issue(8'h41, 8'h00, 0, 0);
    op_valid = 1'b0;
    check("mov_p", sig, CV | MOV | DPRT | idx(1) | RDY);
    issue(8'h80, 8'h00, 0, 0);
    op_valid = 1'b0;
    check("mov_mw", sig, CV | MOV | DW_ | RAM | RDY);
    issue(8'h87, 8'h00, 0, 0);
    op_valid = 1'b0;
    check("mov_lm", sig, CV | MOV | DMEM | RDY);
    idle_cyc();

    issue(8'hA0, 8'h00, 0, 0);
    op_valid = 1'b0;
    check("xch_s0", sig, CV | MOV | DUP);
    @(negedge clk);
    check("xch_s1", sig, CV | STP | MOV | DW_ | DMEM | RDY);
    issue(8'h93, 8'h00, 0, 0);
    op_valid = 1'b0;
    check("mulmw_s0", sig, CV | ALU | MB | DW_ | RAM);
    @(negedge clk);
    check("mulmw_s1", sig, CV | STP | ALU | MB | DMEM | RAM | RDY);

    issue(8'hA8, 8'h00, 0, 0);
    op_valid = 1'b0;
    check("call_s0", sig, CV | PUSH);
    @(negedge clk);
    check("call_s1", sig, CV | STP | JMP | JC | RDY);
    idle_cyc();

    issue(8'h75, 8'h00, 0, 0);
    opcode = 8'h00;
    check("ill75", sig, CV | RDY | ILX);
    @(negedge clk);
    op_valid = 1'b0;
    check("nop00", sig, CV | RDY | ILX);
    @(negedge clk);
    check("ill_sticky", sig, RDY | ILX);

    issue(8'hA8, 8'h00, 0, 0);
    op_valid = 1'b0;
    check("call2_s0", sig, CV | PUSH);
    rst_n = 1'b0; #1;
    check("rst_abort", sig, RDY);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("no_s1", sig, RDY);
    @(negedge clk);
    check("idle_end", sig, RDY);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ucode_seq.md
UCODE_SEQ -- requirements
Module: ucode_seq

Interface
REQ-001 Parameter DW, default 8, width of the W register input; SHALL be at least 8 and a power of two.
REQ-002 Parameter IDXW, default 3, width of dst_index.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 op_valid  input  1  opcode offered. op_ready  output  1  sequencer can accept an opcode.
REQ-006 opcode  input  8  instruction opcode. w  input  DW  W register value. carry, zero  input  1 each  ALU flags.
REQ-007 ctrl_valid  output  1  control bundle valid this cycle. step  output  1  micro-step number (0 or 1).
REQ-008 alu_op, alu_mb, jmp_op, jmp_cond, mov_op, dst_w, dst_f, dst_mem, dst_reg, dst_port, ram_op, dup_w, stack_push  outputs  1 each  control strobes.
REQ-009 dst_index  output  IDXW  register or port index.
REQ-010 illegal  output  1  sticky undefined-opcode flag (see Configuration).

Function
REQ-011 Accept SHALL occur when op_valid and op_ready are both high on a rising edge; opcode, w, carry and zero SHALL be captured at accept.
REQ-012 FSM states: IDLE, S0, S1. IDLE->S0 on accept; S0->S1 for two-step opcodes, else S0->IDLE, or S0->S0 on a same-cycle accept; S1->IDLE, or S1->S0 on a same-cycle accept.
REQ-013 op_ready SHALL be high in IDLE, in S1, and in S0 of a single-step opcode, and low in S0 of a two-step opcode.
REQ-014 ctrl_valid SHALL be high exactly in S0 and S1; step SHALL be 0 in S0 and 1 in S1.
REQ-015 All strobes SHALL be 0 whenever ctrl_valid is 0; there is one-cycle latency from accept to the S0 bundle.
REQ-016 Single-step decode:
- 0x01-0x03, 0x06-0x0A, 0x60-0x6F, and AddLW/SubLW/AndLW/OrLW/XorLW: alu_op, dst_w.
- 0x04-0x05: alu_op, dst_f.
- 0x40-0x41: mov_op, dst_port, dst_index=opcode[2:0]. 0x48-0x49: mov_op, dst_w, dst_index=opcode[2:0].
- 0x50-0x57: mov_op, dst_reg, dst_index=opcode[2:0]. 0x58-0x5F: mov_op, dst_w, dst_index=opcode[2:0].
- MovMW 0x80-0x81: mov_op, dst_w, ram_op. MovWM/MovLM 0x82-0x83/0x86-0x87: mov_op, dst_mem. MovLW 0x84-0x85: mov_op, dst_w.
- AddMW/SubMW/AndMW/OrMW/XorMW: alu_op, dst_w, ram_op.
REQ-017 Jump decode (jmp_op=1): 0xA2-0xA3 jmp_cond=1; 0xA4-0xA5 jmp_cond=captured carry; 0xA6-0xA7 jmp_cond=captured zero; 0xE0-0xEF jmp_cond=!w[opcode[3:1]]; 0xF0-0xFF jmp_cond=w[opcode[3:1]]. Only the captured w SHALL be used; bits above 7 SHALL be ignored.
REQ-018 Two-step decode:
- MulLW 0x90-0x91: S0 alu_op, alu_mb, dst_w; S1 alu_op, alu_mb, dst_mem.
- MulMW 0x92-0x93: as MulLW, with ram_op in both steps.
- XchWM 0xA0-0xA1: S0 mov_op, dup_w; S1 mov_op, dst_w, dst_mem.
- Call 0xA8-0xA9: S0 stack_push; S1 jmp_op, jmp_cond=1.
REQ-019 NOP 0x00 and all unlisted opcodes SHALL give ctrl_valid=1 with every strobe 0 for a single step.
REQ-020 dst_index SHALL be 0 for opcodes other than the MovW/P/R groups; when IDXW>3, opcode[2:0] SHALL be zero-extended.

Reset
REQ-021 While rst_n is low: state=IDLE; ctrl_valid, step, all strobes, dst_index and illegal = 0; op_ready=1.
REQ-022 Reset asserted in S0 or S1 SHALL abort the instruction; no S1 bundle SHALL follow after release.

Configuration
REQ-023 Macro UCODE_SEQ_ILLEGAL_TRAP_EN defined: accepting any opcode in 0x0B-0x3F, 0x42-0x47, 0x4A-0x4F, 0x70-0x7F or 0xAA-0xDF SHALL set illegal in the S0 cycle. illegal SHALL stay set until reset, and the opcode SHALL decode as NOP.
REQ-024 Macro undefined: the illegal output SHALL be tied 0 and no trap logic SHALL exist.

Verification
REQ-025 Accept 0x53 -> next cycle ctrl_valid=1, step=0, mov_op=1, dst_reg=1, dst_index=3, op_ready=1.
REQ-026 Accept 0x90, hold op_valid with 0x02 -> S0 alu_mb+dst_w with op_ready=0; S1 alu_mb+dst_mem with op_ready=1; 0x02 accepted in S1 and its bundle follows immediately.
REQ-027 Accept 0xF6 with w=0x08, then 0xE6 with w=0x08 -> jmp_cond=1, then jmp_cond=0; change w after accept -> no effect.
REQ-028 Accept 0xA8 -> S0 stack_push=1; S1 jmp_op=1, jmp_cond=1; assert rst_n=0 during S0 in a repeat -> no S1, all outputs 0.
REQ-029 With UCODE_SEQ_ILLEGAL_TRAP_EN, accept 0x75 then 0x00 -> illegal=1 from the S0 cycle onward, all strobes 0; without the macro, illegal stays 0.
